// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit scanned 7-segment display.
// Contents:
//   NUM_DIGITS  - number of time-multiplexed digits
//   SEG_BLANK   - all segments off, dp off (active-low)
//   SEG_CODES   - 16-entry hex font, active-low, bit order g..a
//   digit_idx_t - scan position, wraps 7 -> 0
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned SEG_W      = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [DIGIT_W-1:0] digit_idx_t;

  // Active-low g..a patterns for 0-F; dp is added separately by the top.
  localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble - 4-bit value to show
//   seg_c  - segments g..a, active-low (combinational)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_CODES[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Latches a 32-bit debug word (pc/inst) and shows it in hex on an 8-digit
// common-anode multiplexed 7-segment display. All pin outputs are registered.
// Optional macro SEG7_BLANK_LEADING_ZERO_EN blanks leading zero digits
// (digit 0 always shown).
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high
//   cs      - load strobe, captures i_data on each edge where high
//   i_data  - word to display
//   o_seg   - segments, active-low, [7]=dp (always off), [6:0]=g..a
//   o_sel   - digit select, active-low one-hot, bit 0 = rightmost digit
//   o_frame - one-cycle pulse at the end of each 8-digit scan
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [31:0] i_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam digit_idx_t       LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  logic [31:0]      data_reg;
  logic [CNT_W-1:0] div_cnt;
  digit_idx_t       digit_idx;

  logic [3:0]       nibble_c;
  logic [SEG_W-1:0] seg_code_c;
  logic             blank_c;
  logic             div_wrap_c;

  // Current digit's nibble, blanking decision and prescaler wrap, all from
  // pre-edge state so the registered outputs lag by exactly one cycle.
  always_comb begin
    nibble_c   = 4'(data_reg >> {digit_idx, 2'b00});
    div_wrap_c = (div_cnt == DIV_LAST);
    blank_c    = 1'b0;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    blank_c    = (digit_idx != '0) &&
                 ((data_reg >> {digit_idx, 2'b00}) == 32'd0);
`endif
  end

  seg7_hex_decode u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_code_c)
  );

  // Capture register, prescaler, scan counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      o_seg     <= SEG_BLANK;
      o_sel     <= 8'hFF;
      o_frame   <= 1'b0;
    end else begin
      if (cs) data_reg <= i_data;

      if (div_wrap_c) begin
        div_cnt   <= '0;
        digit_idx <= digit_idx + DIGIT_W'(1);
      end else begin
        div_cnt   <= div_cnt + CNT_W'(1);
      end

      o_sel   <= ~(8'(1) << digit_idx);
      o_seg   <= blank_c ? SEG_BLANK : {1'b1, seg_code_c};
      o_frame <= div_wrap_c && (digit_idx == LAST_DIGIT);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display. Three instances share the inputs and
// differ only in SCAN_DIV (4, 8, 1); each test observes the relevant one.
// Edge counter k restarts at 1 on the first edge after reset is released.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [31:0] i_data;

  logic [7:0] seg4, sel4, seg8, sel8, seg1, sel1;
  logic       fr4, fr8, fr1;

  int checks = 0;
  int errors = 0;
  int k      = 0;
  int frames = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.SCAN_DIV(4), .CNT_W(17)) dut4 (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data),
    .o_seg(seg4), .o_sel(sel4), .o_frame(fr4));

  seg7_scan_display #(.SCAN_DIV(8), .CNT_W(17)) dut8 (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data),
    .o_seg(seg8), .o_sel(sel8), .o_frame(fr8));

  seg7_scan_display #(.SCAN_DIV(1), .CNT_W(17)) dut1 (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data),
    .o_seg(seg1), .o_sel(sel1), .o_frame(fr1));

  localparam logic [7:0] CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] exp_seg(input logic [31:0] d, input int dig);
    logic [31:0] s;
    s = d >> (4 * dig);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    if (dig != 0 && s == 32'd0) return 8'hFF;
`endif
    return CODES[s[3:0]];
  endfunction

  function automatic logic [7:0] exp_sel(input int dig);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << dig);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  // One reset edge, then release; returns after the first post-reset edge (k=1).
  task automatic restart();
    reset = 1'b1;
    cs    = 1'b0;
    step();
    reset = 1'b0;
    k     = 0;
    step();
  endtask

  task automatic load(input logic [31:0] d);
    cs     = 1'b1;
    i_data = d;
    step();
    cs     = 1'b0;
  endtask

  // Eight SCAN_DIV=1 edges after a load: digit under display is (k-1)%8.
  task automatic scan8_dut1(input string tag, input logic [31:0] d);
    for (int n = 0; n < 8; n++) begin
      step();
      chk({tag, "_sel"}, sel1, exp_sel((k - 1) % 8));
      chk({tag, "_seg"}, seg1, exp_seg(d, (k - 1) % 8));
      chk({tag, "_frame"}, {7'b0, fr1}, {7'b0, (k % 8) == 0});
    end
  endtask

  initial begin
    reset  = 1'b1;
    cs     = 1'b0;
    i_data = 32'h0;

    // Reset held 3 cycles: outputs blank/deselected.
    for (int n = 0; n < 3; n++) begin
      step();
      chk("rst_seg", seg4, 8'hFF);
      chk("rst_sel", sel4, 8'hFF);
      chk("rst_frame", {7'b0, fr4}, 8'h00);
    end

    // First edge after release shows digit 0 of zero.
    reset = 1'b0;
    k = 0;
    step();
    chk("first_sel4", sel4, 8'hFE);
    chk("first_seg4", seg4, 8'hC0);
    chk("first_sel1", sel1, 8'hFE);
    chk("first_seg8", seg8, 8'hC0);

    // Scan order with SCAN_DIV=4 and 32'h0040_0000 (digit 5 = '4').
    load(32'h0040_0000);
    chk("scan_preload_seg", seg4, 8'hC0);
    frames = 0;
    while (k < 69) begin
      step();
      chk("scan_sel", sel4, exp_sel(((k - 1) / 4) % 8));
      chk("scan_seg", seg4, exp_seg(32'h0040_0000, ((k - 1) / 4) % 8));
      chk("scan_frame", {7'b0, fr4}, {7'b0, (k % 32) == 0});
      if (fr4) frames++;
    end
    chk("scan_frame_count", 8'(frames), 8'd2);

    // Capture latency with SCAN_DIV=8 while on digit 0.
    restart();
    load(32'h0000_0007);
    chk("cap_edge_seg", seg8, 8'hC0);
    step();
    chk("cap_lat_seg", seg8, 8'hF8);
    chk("cap_lat_sel", sel8, 8'hFE);
    i_data = 32'h0000_000F;
    step();
    step();
    chk("cap_hold_seg", seg8, 8'hF8);
    while (k < 9) step();
    chk("cap_next_sel", sel8, 8'hFD);
    chk("cap_next_seg", seg8, 8'hC0);

    // Full decode table with SCAN_DIV=1.
    restart();
    load(32'h89AB_CDEF);
    scan8_dut1("dec_hi", 32'h89AB_CDEF);
    load(32'h0123_4567);
    chk("dec_swap_seg", seg1, exp_seg(32'h89AB_CDEF, (k - 1) % 8));
    scan8_dut1("dec_lo", 32'h0123_4567);

    // Leading-zero handling (blanked only when the macro is defined).
    load(32'h0000_0A00);
    scan8_dut1("lz_a00", 32'h0000_0A00);
    load(32'h0000_0000);
    scan8_dut1("lz_zero", 32'h0000_0000);

    // Reset mid-scan: SCAN_DIV=4, on digit 5 with div_cnt=2.
    restart();
    load(32'hFFFF_FFFF);
    while (k < 22) step();
    chk("mid_pre_sel", sel4, 8'hDF);
    chk("mid_pre_seg", seg4, 8'h8E);
    reset = 1'b1;
    step();
    chk("mid_rst_seg", seg4, 8'hFF);
    chk("mid_rst_sel", sel4, 8'hFF);
    chk("mid_rst_frame", {7'b0, fr4}, 8'h00);
    reset = 1'b0;
    step();
    chk("mid_restart_sel", sel4, 8'hFE);
    chk("mid_restart_seg", seg4, 8'hC0);
    step();
    chk("mid_data_cleared", seg4, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
